// File: rtl/wb_trace_buffer.sv
// ============================================================================
// wb_trace_buffer
// ----------------------------------------------------------------------------
// Writeback trace buffer that sits beside the pipeline W stage. It captures
// register-file write events from CH write ports into a DEPTH-entry
// first-word-fall-through FIFO. Records are read out over a valid/ready
// handshake. An arm/trigger/stop state machine controls when capture happens.
// Events that do not fit are dropped and counted.
//
// Record layout (rd_data_o): {timestamp[TS_W], port[3:0], reg[3:0], data[DATA_W]}
//
// Optional build macro: TRACE_TIMESTAMP_EN
//   defined   -> a free-running TS_W timestamp counter fills the timestamp field
//   undefined -> no counter is built and the timestamp field reads 0
//   Port widths are the same in both builds.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-low reset
//   arm_i        in   pulse: start (or restart) a capture session
//   stop_i       in   pulse: end capture (wins over arm_i)
//   flush_i      in   empty FIFO, clear overflow and drop count
//   trig_en_i    in   1 = wait for a trigger match before capturing
//   trig_reg_i   in   trigger register address
//   trig_val_i   in   trigger data value
//   we_i         in   per-port write enable
//   wa_i         in   per-port register address, port k at [4k+3:4k]
//   wd_i         in   per-port write data, port k at [DATA_W*k +: DATA_W]
//   rd_valid_o   out  FIFO head valid
//   rd_ready_i   in   consumer accepts head
//   rd_data_o    out  head record (0 when empty)
//   count_o      out  FIFO occupancy
//   overflow_o   out  sticky: at least one event dropped
//   drop_cnt_o   out  dropped-event count, saturating
//   state_o      out  IDLE=0, ARMED=1, CAPTURE=2, STOPPED=3
// ============================================================================
module wb_trace_buffer #(
    parameter int DATA_W       = 32,
    parameter int CH           = 2,
    parameter int DEPTH        = 16,
    parameter int TS_W         = 16,
    parameter int STOP_ON_FULL = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         arm_i,
    input  logic                         stop_i,
    input  logic                         flush_i,
    input  logic                         trig_en_i,
    input  logic [3:0]                   trig_reg_i,
    input  logic [DATA_W-1:0]            trig_val_i,
    input  logic [CH-1:0]                we_i,
    input  logic [4*CH-1:0]              wa_i,
    input  logic [DATA_W*CH-1:0]         wd_i,
    output logic                         rd_valid_o,
    input  logic                         rd_ready_i,
    output logic [TS_W+8+DATA_W-1:0]     rd_data_o,
    output logic [$clog2(DEPTH):0]       count_o,
    output logic                         overflow_o,
    output logic [15:0]                  drop_cnt_o,
    output logic [1:0]                   state_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    // One extra bit so free-space and per-port slot arithmetic never wraps.
    localparam int NW    = CW + 1;
    localparam int REC_W = TS_W + 8 + DATA_W;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_STOPPED = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       drop_q, drop_d;
    logic [REC_W-1:0]  mem_q [DEPTH];

    logic              arm_eff;
    logic              pop;
    logic              capture_en;
    logic              full_stop;
    state_t            arm_target;
    logic [TS_W-1:0]   ts_rec;
    logic [CH-1:0]     hit;
    logic [CH-1:0]     acc;
    logic [NW-1:0]     slot [CH];
    logic [NW-1:0]     free_sp;
    logic [NW-1:0]     n_en;
    logic [NW-1:0]     n_acc;
    logic [NW-1:0]     n_drop;
    logic [16:0]       drop_sum;
    logic [REC_W-1:0]  rec_w [CH];

    // stop_i has priority, so a coincident arm_i is ignored entirely
    // (including its timestamp clear).
    assign arm_eff    = arm_i & ~stop_i;
    assign arm_target = trig_en_i ? S_ARMED : S_CAPTURE;
    assign rd_valid_o = (count_q != '0);
    assign pop        = rd_valid_o & rd_ready_i;

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q, ts_d;

    assign ts_d   = arm_eff ? '0 : ts_q + 1'b1;
    // Records carry the counter value established by their capture edge.
    assign ts_rec = ts_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end
`else
    assign ts_rec = '0;
`endif

    // Per-port trigger comparison and record formatting.
    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_port
            assign hit[gi]   = we_i[gi]
                             && (wa_i[4*gi +: 4] == trig_reg_i)
                             && (wd_i[DATA_W*gi +: DATA_W] == trig_val_i);
            assign rec_w[gi] = {ts_rec, 4'(gi), wa_i[4*gi +: 4],
                                wd_i[DATA_W*gi +: DATA_W]};
        end
    endgenerate

    // The triggering cycle itself is captured, so ARMED captures on a hit.
    assign capture_en = (state_q == S_CAPTURE) || ((state_q == S_ARMED) && (|hit));

    // A popped entry frees its slot for this cycle's pushes.
    assign free_sp = NW'(DEPTH) - NW'(count_q) + NW'(pop);

    // Ports are packed in ascending order; each enabled port takes the next
    // slot, and anything past the free space is dropped (highest index first).
    always_comb begin
        n_en  = '0;
        n_acc = '0;
        acc   = '0;
        for (int k = 0; k < CH; k++) begin
            slot[k] = n_en;
            if (capture_en && we_i[k]) begin
                n_en = n_en + 1'b1;
                if (slot[k] < free_sp) begin
                    acc[k] = 1'b1;
                    n_acc  = n_acc + 1'b1;
                end
            end
        end
        n_drop = n_en - n_acc;
    end

    assign drop_sum = {1'b0, drop_q} + 17'(n_drop);

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (flush_i) begin
            wptr_d     = '0;
            rptr_d     = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            drop_d     = '0;
        end else begin
            wptr_d  = wptr_q + AW'(n_acc);
            rptr_d  = rptr_q + AW'(pop);
            count_d = count_q + CW'(n_acc) - CW'(pop);
            if (n_drop != '0) begin
                overflow_d = 1'b1;
                drop_d     = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            end
        end
    end

    assign full_stop = (STOP_ON_FULL != 0) && capture_en && (count_d == CW'(DEPTH));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (arm_eff) state_d = arm_target;
            end
            S_ARMED: begin
                if (stop_i)       state_d = S_STOPPED;
                else if (arm_eff) state_d = arm_target;
                else if (|hit)    state_d = full_stop ? S_STOPPED : S_CAPTURE;
            end
            S_CAPTURE: begin
                if (stop_i)         state_d = S_STOPPED;
                else if (arm_eff)   state_d = arm_target;
                else if (full_stop) state_d = S_STOPPED;
            end
            S_STOPPED: begin
                if (arm_eff) state_d = arm_target;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // Storage needs no reset: the read port is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        for (int k = 0; k < CH; k++) begin
            if (acc[k] && !flush_i) begin
                mem_q[wptr_q + AW'(slot[k])] <= rec_w[k];
            end
        end
    end

    assign rd_data_o  = rd_valid_o ? mem_q[rptr_q] : '0;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign drop_cnt_o = drop_q;
    assign state_o    = state_q;

endmodule
